// File: rtl/apb_pkg.sv
// Shared APB types and the register-bank address decoder.
package apb_pkg;

    localparam int APB_DW = 32;
    localparam int APB_AW = 32;

    typedef enum logic [1:0] {IDLE, SETUP, WAIT, READY} apb_state_e;

    typedef struct packed {
        logic              err;
        logic [APB_AW-3:0] index;
    } apb_dec_t;

    // offset carries one extra MSB: it is set when paddr was below the base address
    function automatic apb_dec_t apb_decode(input logic [APB_AW:0] offset,
                                            input logic            write,
                                            input int unsigned     nregs);
        apb_dec_t d;
        d.index = offset[APB_AW-1:2];
        d.err   = offset[APB_AW]
                | (offset[1:0] != 2'b00)
                | ({2'b00, d.index} >= nregs)
                | (write & (d.index == '0));
        return d;
    endfunction

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB3 completer-side signal bundle.
interface apb_reg_slave_if;
    import apb_pkg::*;

    logic              psel_i;
    logic              penable_i;
    logic [APB_AW-1:0] paddr_i;
    logic              pwrite_i;
    logic [APB_DW-1:0] pwdata_i;
    logic [APB_DW-1:0] prdata_o;
    logic              pready_o;
    logic              pslverr_o;

    modport master (
        output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );

endinterface

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter that flags when it has reached zero.
module apb_wait_ctr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/apb_reg_slave.sv
// APB3 register-bank completer: read-only ID at index 0, configurable wait states,
// pslverr on misaligned, out-of-range or read-only accesses.
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input logic            pclk,
    input logic            preset,
    apb_reg_slave_if.slave bus
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CTR_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CTR_W-1:0] CTR_LOAD = CTR_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    apb_state_e        state, state_nxt, phase;
    logic [APB_DW-1:0] regs [NUM_REGS];
    logic [APB_AW:0]   offset;
    apb_dec_t          dec;
    logic [IDX_W-1:0]  idx, idx_q;
    logic [APB_DW-1:0] rd_val, rdata_q, wdata_q, rdata_nxt;
    logic              err_q, wr_q, err_nxt, ready_nxt;
    logic              load, dec_en, wr_en, ctr_done, setup_ph, xfer_on;
    logic              unused_idx_hi;

    assign setup_ph      = bus.psel_i & ~bus.penable_i;
    assign xfer_on       = bus.psel_i & bus.penable_i;
    assign offset        = {1'b0, bus.paddr_i} - {1'b0, BASE_ADDR};
    assign dec           = apb_decode(offset, bus.pwrite_i, $unsigned(NUM_REGS));
    assign idx           = dec.index[IDX_W-1:0];
    assign unused_idx_hi = ^dec.index[APB_AW-3:IDX_W];

    always_comb begin
        rd_val = '0;
        if (!dec.err && !bus.pwrite_i) begin
            rd_val = (idx == '0) ? ID_VALUE : regs[idx];
        end
    end

    apb_wait_ctr #(.W(CTR_W)) u_wait_ctr (
        .clk      (pclk),
        .rst      (preset),
        .load     (load),
        .dec      (dec_en),
        .load_val (CTR_LOAD),
        .done     (ctr_done)
    );

    // The setup phase is recognised combinationally so its decode is registered at the
    // edge that opens the access phase; this is what makes zero-wait reads possible.
    always_comb begin
        phase     = state;
        state_nxt = state;
        load      = 1'b0;
        dec_en    = 1'b0;
        wr_en     = 1'b0;
        ready_nxt = 1'b0;
        err_nxt   = 1'b0;
        rdata_nxt = '0;
        if (state == IDLE && setup_ph) begin
            phase = SETUP;
        end
        case (phase)
            IDLE: state_nxt = IDLE;
            SETUP: begin
                load = 1'b1;
                if (WAIT_CYCLES == 0) begin
                    state_nxt = READY;
                    ready_nxt = 1'b1;
                    err_nxt   = dec.err;
                    rdata_nxt = rd_val;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!xfer_on) begin
                    state_nxt = IDLE;
                end else if (ctr_done) begin
                    state_nxt = READY;
                    ready_nxt = 1'b1;
                    err_nxt   = err_q;
                    rdata_nxt = rdata_q;
                end else begin
                    dec_en = 1'b1;
                end
            end
            READY: begin
                state_nxt = IDLE;
                wr_en     = xfer_on & wr_q & ~err_q;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state         <= IDLE;
            err_q         <= 1'b0;
            wr_q          <= 1'b0;
            idx_q         <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            bus.prdata_o  <= '0;
            bus.pready_o  <= 1'b0;
            bus.pslverr_o <= 1'b0;
        end else begin
            state         <= state_nxt;
            bus.prdata_o  <= rdata_nxt;
            bus.pready_o  <= ready_nxt;
            bus.pslverr_o <= err_nxt;
            if (load) begin
                err_q   <= dec.err;
                wr_q    <= bus.pwrite_i;
                idx_q   <= idx;
                wdata_q <= bus.pwdata_i;
                rdata_q <= rd_val;
            end
        end
    end

    // Index 0 is never written: the decoder flags it as an error for writes
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: one instance with one wait state, one zero-wait.
module tb_apb_reg_slave;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel, penable, pwrite, sel;
    logic [31:0] paddr, pwdata;
    logic        rdy, serr;
    logic [31:0] rdat;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 pclk = ~pclk;

    apb_reg_slave_if bus1();
    apb_reg_slave_if bus0();

    assign bus1.psel_i    = psel & sel;
    assign bus1.penable_i = penable & sel;
    assign bus1.paddr_i   = paddr;
    assign bus1.pwrite_i  = pwrite;
    assign bus1.pwdata_i  = pwdata;
    assign bus0.psel_i    = psel & ~sel;
    assign bus0.penable_i = penable & ~sel;
    assign bus0.paddr_i   = paddr;
    assign bus0.pwrite_i  = pwrite;
    assign bus0.pwdata_i  = pwdata;

    assign rdy  = sel ? bus1.pready_o  : bus0.pready_o;
    assign serr = sel ? bus1.pslverr_o : bus0.pslverr_o;
    assign rdat = sel ? bus1.prdata_o  : bus0.prdata_o;

    apb_reg_slave #(.NUM_REGS(8), .WAIT_CYCLES(1), .BASE_ADDR(32'h0), .ID_VALUE(32'hA5B0_0001))
        dut1 (.pclk(pclk), .preset(preset), .bus(bus1));
    apb_reg_slave #(.NUM_REGS(8), .WAIT_CYCLES(0), .BASE_ADDR(32'h0), .ID_VALUE(32'hA5B0_0001))
        dut0 (.pclk(pclk), .preset(preset), .bus(bus0));

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic exp_err, input logic [31:0] exp_rd);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_err = exp_err; v.exp_rd = exp_rd;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h, required %h", name, idx, act, exp);
    endtask

    // Entered and left at 1 time unit after a rising edge; the next transfer may start at once.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd_o, output logic err_o, output int lat_o);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge pclk); #1;
        penable = 1'b1;
        lat_o = 1;
        while (!rdy && lat_o < 16) begin
            @(posedge pclk); #1;
            lat_o++;
        end
        rd_o = rdat;
        err_o = serr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; sel = 1'b1;

        vecs[0]  = mk(1'b1, 32'h08, 32'hDEAD_BEEF, 1'b0, 32'h0);
        vecs[1]  = mk(1'b0, 32'h08, 32'h0,         1'b0, 32'hDEAD_BEEF);
        vecs[2]  = mk(1'b0, 32'h00, 32'h0,         1'b0, 32'hA5B0_0001);
        vecs[3]  = mk(1'b1, 32'h00, 32'h1,         1'b1, 32'h0);
        vecs[4]  = mk(1'b0, 32'h00, 32'h0,         1'b0, 32'hA5B0_0001);
        vecs[5]  = mk(1'b0, 32'h20, 32'h0,         1'b1, 32'h0);
        vecs[6]  = mk(1'b1, 32'h06, 32'hCAFE,      1'b1, 32'h0);
        vecs[7]  = mk(1'b0, 32'h04, 32'h0,         1'b0, 32'h0);
        vecs[8]  = mk(1'b0, 32'h08, 32'h0,         1'b0, 32'hDEAD_BEEF);
        vecs[9]  = mk(1'b1, 32'h1C, 32'h77,        1'b0, 32'h0);
        vecs[10] = mk(1'b0, 32'h1C, 32'h0,         1'b0, 32'h77);
        vecs[11] = mk(1'b0, 32'h18, 32'h0,         1'b0, 32'h0);
        vecs[12] = mk(1'b0, 32'h1D, 32'h0,         1'b1, 32'h0);
        vecs[13] = mk(1'b0, 32'hFFFF_FFFC, 32'h0,  1'b1, 32'h0);

        // reset state
        @(posedge pclk); #1;
        check("rst_ready1", 0, 32'(bus1.pready_o), 32'h0);
        check("rst_err1",   0, 32'(bus1.pslverr_o), 32'h0);
        check("rst_rdata1", 0, bus1.prdata_o, 32'h0);
        check("rst_ready0", 0, 32'(bus0.pready_o), 32'h0);
        check("rst_err0",   0, 32'(bus0.pslverr_o), 32'h0);
        check("rst_rdata0", 0, bus0.prdata_o, 32'h0);
        @(posedge pclk); #1;
        preset = 1'b0;
        @(posedge pclk); #1;

        // table: one wait state, so every transfer takes two access cycles
        for (int i = 0; i < NV; i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, lat);
            check("vec_lat", i, lat, 32'd2);
            check("vec_err", i, 32'(err), 32'(vecs[i].exp_err));
            if (!vecs[i].wr || vecs[i].exp_err) check("vec_rdata", i, rd, vecs[i].exp_rd);
        end

        // abort: psel dropped during WAIT
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h1234;
        @(posedge pclk); #1;
        penable = 1'b1;
        check("abort_wait_ready", 0, 32'(rdy), 32'h0);
        psel = 1'b0; penable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge pclk); #1;
            check("abort_ready", k, 32'(rdy), 32'h0);
            check("abort_err", k, 32'(serr), 32'h0);
        end
        xfer(1'b0, 32'h10, 32'h0, rd, err, lat);
        check("abort_rd_lat", 0, lat, 32'd2);
        check("abort_rd_err", 0, 32'(err), 32'h0);
        check("abort_rd_data", 0, rd, 32'h0);

        // reset asserted while READY of a write
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'hFFFF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        check("midrst_pre_ready", 0, 32'(rdy), 32'h1);
        #2 preset = 1'b1;
        #1;
        check("midrst_ready", 0, 32'(rdy), 32'h0);
        check("midrst_err",   0, 32'(serr), 32'h0);
        check("midrst_rdata", 0, rdat, 32'h0);
        @(posedge pclk); #1;
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        xfer(1'b0, 32'h14, 32'h0, rd, err, lat);
        check("midrst_rd14", 0, rd, 32'h0);
        check("midrst_rd14_err", 0, 32'(err), 32'h0);
        xfer(1'b0, 32'h08, 32'h0, rd, err, lat);
        check("midrst_rd08", 0, rd, 32'h0);

        // zero-wait instance, back-to-back transfers
        sel = 1'b0;
        xfer(1'b1, 32'h04, 32'h0000_AAAA, rd, err, lat);
        check("zw_wr04_lat", 0, lat, 32'd1);
        check("zw_wr04_err", 0, 32'(err), 32'h0);
        xfer(1'b1, 32'h0C, 32'h0000_5555, rd, err, lat);
        check("zw_wr0c_lat", 0, lat, 32'd1);
        check("zw_wr0c_err", 0, 32'(err), 32'h0);
        xfer(1'b0, 32'h04, 32'h0, rd, err, lat);
        check("zw_rd04_lat", 0, lat, 32'd1);
        check("zw_rd04", 0, rd, 32'h0000_AAAA);
        xfer(1'b0, 32'h0C, 32'h0, rd, err, lat);
        check("zw_rd0c_lat", 0, lat, 32'd1);
        check("zw_rd0c", 0, rd, 32'h0000_5555);
        xfer(1'b0, 32'h00, 32'h0, rd, err, lat);
        check("zw_rd_id", 0, rd, 32'hA5B0_0001);
        xfer(1'b0, 32'h20, 32'h0, rd, err, lat);
        check("zw_oor_err", 0, 32'(err), 32'h1);
        check("zw_oor_data", 0, rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
